// File: rtl/des_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_apb_pkg
// Description : Shared types and constants for the 3DES APB slave controller:
//               command codes, register addresses and status bit offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package des_apb_pkg;

    // Command codes presented to the datapath alongside cmd_valid
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_ENC   = 3'd1,
        CMD_DEC   = 3'd2,
        CMD_KEY   = 3'd3,
        CMD_RESET = 3'd5,
        CMD_READ  = 3'd6
    } cmd_e;

    // APB word addresses
    localparam logic [2:0] c_addr_enc    = 3'd0;
    localparam logic [2:0] c_addr_dec    = 3'd1;
    localparam logic [2:0] c_addr_key    = 3'd2;
    localparam logic [2:0] c_addr_rst    = 3'd3;
    localparam logic [2:0] c_addr_data   = 3'd4;
    localparam logic [2:0] c_addr_incnt  = 3'd5;
    localparam logic [2:0] c_addr_outcnt = 3'd6;
    localparam logic [2:0] c_addr_stat   = 3'd7;

    // Status flag positions, counted upward from the top of the key_idx field
    localparam int c_stat_active_ofs = 0;
    localparam int c_stat_abort_ofs  = 1;
    localparam int c_stat_err_ofs    = 2;

endpackage
`default_nettype wire

// File: rtl/des_key_seq.sv
`default_nettype none
// ============================================================================
// Module      : des_key_seq
// Description : Key-load sequencer. Tracks which key word is next, whether a
//               sequence is in progress, and aborts a stalled sequence after
//               KEY_TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_seq
    import des_apb_pkg::*;
#(
    parameter int KEY_WORDS   = 6,
    parameter int KEY_TIMEOUT = 255,
    parameter int IDX_W       = $clog2(KEY_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wr,
    input  logic             abort,
    output logic [IDX_W-1:0] key_idx,
    output logic             key_active,
    output logic             timeout_abort
);

    localparam int                 c_tmo_w    = $clog2(KEY_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(KEY_WORDS - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(KEY_TIMEOUT - 1);

    logic [IDX_W-1:0]   r_idx;
    logic               r_active;
    logic [c_tmo_w-1:0] r_tmo;
    logic               w_timeout;

    // The last allowed idle cycle; a key write in the same cycle takes priority
    assign w_timeout = r_active && !key_wr && !abort && (r_tmo == c_tmo_last);

    // Index, active flag and idle counter; r_idx is the index of the next key word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_active <= 1'b0;
            r_tmo    <= '0;
        end else if (abort || w_timeout) begin
            r_idx    <= '0;
            r_active <= 1'b0;
            r_tmo    <= '0;
        end else if (key_wr) begin
            r_tmo <= '0;
            if (r_idx == c_idx_last) begin
                r_idx    <= '0;
                r_active <= 1'b0;
            end else begin
                r_idx    <= r_idx + 1'b1;
                r_active <= 1'b1;
            end
        end else if (r_active) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign key_idx       = r_idx;
    assign key_active    = r_active;
    assign timeout_abort = w_timeout;

endmodule
`default_nettype wire

// File: rtl/des_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : des_apb_ctrl
// Description : APB3 slave front end of the 3DES accelerator. Decodes bus
//               transfers into one-cycle datapath commands, pops the output
//               FIFO with one wait state, and keeps a sticky status register.
// Revision    : 1.0 - initial release
// ============================================================================
module des_apb_ctrl
    import des_apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IN_DEPTH    = 24,
    parameter int OUT_DEPTH   = 24,
    parameter int KEY_WORDS   = 6,
    parameter int KEY_TIMEOUT = 255,
    parameter int CNT_W       = $clog2(IN_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [2:0]                   PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [CNT_W-1:0]             in_cnt,
    input  logic [CNT_W-1:0]             out_cnt,
    input  logic [DATA_W-1:0]            out_data,
    output cmd_e                         cmd,
    output logic                         cmd_valid,
    output logic [$clog2(KEY_WORDS)-1:0] key_idx,
    output logic [DATA_W-1:0]            wr_data,
    output logic                         out_pop
);

    localparam int c_ki_w = $clog2(KEY_WORDS);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_access  = 2'd1;
    localparam logic [1:0] c_st_rd_wait = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_err;
    logic              r_key_abort;
    logic              w_key_wr;
    logic              w_key_clr;
    logic              w_err_set;
    logic              w_stat_wr;
    logic              w_timeout_abort;
    logic              w_key_active;
    logic [c_ki_w-1:0] w_key_idx;
    logic              w_in_full;
    logic [DATA_W-1:0] w_status;

    des_key_seq #(
        .KEY_WORDS   (KEY_WORDS),
        .KEY_TIMEOUT (KEY_TIMEOUT),
        .IDX_W       (c_ki_w)
    ) u_key_seq (
        .clk           (clk),
        .rst           (rst),
        .key_wr        (w_key_wr),
        .abort         (w_key_clr),
        .key_idx       (w_key_idx),
        .key_active    (w_key_active),
        .timeout_abort (w_timeout_abort)
    );

    assign key_idx   = w_key_idx;
    assign w_in_full = (in_cnt == CNT_W'(IN_DEPTH));

    // Status word: key_idx in the LSBs with the flags stacked directly above it
    always_comb begin
        w_status                               = '0;
        w_status[c_ki_w-1:0]                   = w_key_idx;
        w_status[c_ki_w + c_stat_active_ofs]   = w_key_active;
        w_status[c_ki_w + c_stat_abort_ofs]    = r_key_abort;
        w_status[c_ki_w + c_stat_err_ofs]      = r_err;
    end

    // Bus state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer decode; everything is held low while rst is asserted so a
    // transfer in flight is dropped without a completion
    always_comb begin
        w_state_nxt = r_state;
        PREADY      = 1'b0;
        PRDATA      = '0;
        cmd         = CMD_NONE;
        cmd_valid   = 1'b0;
        out_pop     = 1'b0;
        w_key_wr    = 1'b0;
        w_key_clr   = 1'b0;
        w_err_set   = 1'b0;
        w_stat_wr   = 1'b0;
        if (!rst) begin
            case (r_state)
                c_st_idle: begin
                    if (PSEL && !PENABLE) w_state_nxt = c_st_access;
                end
                c_st_access: begin
                    if (!PSEL) begin
                        w_state_nxt = c_st_idle;
                    end else if (PENABLE) begin
                        w_state_nxt = c_st_idle;
                        PREADY      = 1'b1;
                        if (PWRITE) begin
                            case (PADDR)
                                c_addr_enc, c_addr_dec: begin
                                    if (w_in_full || w_key_active) begin
                                        w_err_set = 1'b1;
                                    end else begin
                                        cmd_valid = 1'b1;
                                        cmd       = (PADDR == c_addr_enc) ? CMD_ENC : CMD_DEC;
                                    end
                                end
                                c_addr_key: begin
                                    cmd_valid = 1'b1;
                                    cmd       = CMD_KEY;
                                    w_key_wr  = 1'b1;
                                end
                                c_addr_rst: begin
                                    cmd_valid = 1'b1;
                                    cmd       = CMD_RESET;
                                    w_key_clr = 1'b1;
                                end
                                c_addr_stat: w_stat_wr = 1'b1;
                                default:     w_err_set = 1'b1;
                            endcase
                        end else begin
                            case (PADDR)
                                c_addr_data: begin
                                    if (out_cnt == '0) begin
                                        w_err_set = 1'b1;
                                    end else begin
                                        // Head word arrives one cycle after the pop
                                        PREADY      = 1'b0;
                                        out_pop     = 1'b1;
                                        cmd         = CMD_READ;
                                        w_state_nxt = c_st_rd_wait;
                                    end
                                end
                                c_addr_incnt:  PRDATA = DATA_W'(in_cnt);
                                c_addr_outcnt: PRDATA = DATA_W'(out_cnt);
                                c_addr_stat:   PRDATA = w_status;
                                default:       w_err_set = 1'b1;
                            endcase
                        end
                    end
                end
                c_st_rd_wait: begin
                    PREADY      = 1'b1;
                    PRDATA      = out_data;
                    w_state_nxt = c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
        PSLVERR = w_err_set;
        wr_data = cmd_valid ? PWDATA : '0;
    end

    // Sticky flags; a new event outranks a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_key_abort <= 1'b0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_stat_wr && PWDATA[c_ki_w + c_stat_err_ofs]) begin
                r_err <= 1'b0;
            end
            if (w_timeout_abort) begin
                r_key_abort <= 1'b1;
            end else if (w_stat_wr && PWDATA[c_ki_w + c_stat_abort_ofs]) begin
                r_key_abort <= 1'b0;
            end
        end
    end

    // An output occupancy above capacity means the FIFO bookkeeping is corrupt
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(out_cnt) <= OUT_DEPTH);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_apb_ctrl
// Description : Scoreboard bench for des_apb_ctrl: directed scenarios followed
//               by random APB traffic against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_apb_ctrl;
    import des_apb_pkg::*;

    localparam int DATA_W      = 32;
    localparam int IN_DEPTH    = 24;
    localparam int OUT_DEPTH   = 24;
    localparam int KEY_WORDS   = 6;
    localparam int KEY_TIMEOUT = 255;
    localparam int CNT_W       = $clog2(IN_DEPTH + 1);
    localparam int KI          = $clog2(KEY_WORDS);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              PSEL, PENABLE, PWRITE;
    logic [2:0]        PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA, out_data, wr_data;
    logic              PREADY, PSLVERR, cmd_valid, out_pop;
    logic [CNT_W-1:0]  in_cnt, out_cnt;
    cmd_e              cmd;
    logic [KI-1:0]     key_idx;

    des_apb_ctrl #(
        .DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH),
        .KEY_WORDS(KEY_WORDS), .KEY_TIMEOUT(KEY_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .in_cnt(in_cnt), .out_cnt(out_cnt), .out_data(out_data),
        .cmd(cmd), .cmd_valid(cmd_valid), .key_idx(key_idx), .wr_data(wr_data),
        .out_pop(out_pop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        slverr;
        logic [31:0] rdata;
        logic        waited;
        logic        cv;
        logic [2:0]  cmd;
        logic [KI-1:0] kidx;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: sticky flags, key words accepted in the current
    // sequence and the cycle of the most recent key write
    bit m_err, m_kabort;
    int m_key_n, m_last_key;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_kabort = 0; m_key_n = 0; m_last_key = 0;
    endtask

    // Predict the response of one transfer whose access phase is cycle a
    task automatic model_txn(input bit wr, input logic [2:0] addr, input logic [31:0] data, input int a);
        exp_t e = '0;
        bit   err_acc = 0;
        if (m_key_n > 0 && (a - m_last_key) > KEY_TIMEOUT) begin
            m_key_n  = 0;
            m_kabort = 1;
        end
        if (wr) begin
            case (addr)
                3'd0, 3'd1: begin
                    if (int'(in_cnt) == IN_DEPTH || m_key_n > 0) err_acc = 1;
                    else begin
                        e.cv = 1; e.cmd = (addr == 3'd0) ? 3'd1 : 3'd2; e.wdata = data;
                    end
                end
                3'd2: begin
                    e.cv = 1; e.cmd = 3'd3; e.wdata = data; e.kidx = KI'(m_key_n);
                    m_key_n    = (m_key_n + 1) % KEY_WORDS;
                    m_last_key = a;
                end
                3'd3: begin
                    e.cv = 1; e.cmd = 3'd5; e.wdata = data; m_key_n = 0;
                end
                3'd7: begin
                    if (data[KI+2]) m_err = 0;
                    if (data[KI+1]) m_kabort = 0;
                end
                default: err_acc = 1;
            endcase
        end else begin
            case (addr)
                3'd4: begin
                    if (out_cnt == 0) err_acc = 1;
                    else begin e.waited = 1; e.rdata = out_data; end
                end
                3'd5: e.rdata = 32'(in_cnt);
                3'd6: e.rdata = 32'(out_cnt);
                3'd7: e.rdata = 32'(m_key_n) | (32'(m_key_n > 0) << KI)
                              | (32'(m_kabort) << (KI + 1)) | (32'(m_err) << (KI + 2));
                default: err_acc = 1;
            endcase
        end
        if (err_acc) begin
            e.slverr = 1;
            m_err    = 1;
        end
        exp_q.push_back(e);
    endtask

    // Full APB transfer: setup, access, wait for PREADY, release the bus
    task automatic apb(input bit wr, input logic [2:0] addr, input logic [31:0] data);
        int n = 0;
        @(posedge clk); #1;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        PENABLE = 1;
        model_txn(wr, addr, data, cyc);
        do begin
            @(negedge clk);
            n++;
        end while (!PREADY && n < 4);
        if (!PREADY) chk("ready_timeout", 32'(PREADY), 32'd1);
        @(posedge clk); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    // Monitor: every completion is compared against the oldest prediction
    initial begin : monitor
        exp_t e;
        bit   pop_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pop_seen = 0;
                continue;
            end
            if (PREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(PREADY), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pslverr", 32'(PSLVERR), 32'(e.slverr));
                    chk("prdata", PRDATA, e.rdata);
                    chk("wait_state", 32'(pop_seen), 32'(e.waited));
                    chk("cmd_valid", 32'(cmd_valid), 32'(e.cv));
                    chk("pop_at_ready", 32'(out_pop), 32'd0);
                    if (e.cv) begin
                        chk("cmd", 32'(cmd), 32'(e.cmd));
                        chk("wr_data", wr_data, e.wdata);
                        if (e.cmd == 3'd3) chk("key_idx", 32'(key_idx), 32'(e.kidx));
                    end
                end
                pop_seen = 0;
            end else if (cmd_valid) begin
                chk("cmd_without_ready", 32'(cmd_valid), 32'd0);
            end
            if (out_pop && !PREADY) pop_seen = 1;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit   wr;
        logic [2:0] addr;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        in_cnt = '0; out_cnt = '0; out_data = '0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_pready", 32'(PREADY), 0);
        chk("rst_pslverr", 32'(PSLVERR), 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_key_idx", 32'(key_idx), 0);
        chk("rst_out_pop", 32'(out_pop), 0);
        chk("rst_wr_data", wr_data, 0);
        apb(0, 3'd7, 0);

        // Encrypt command, full input FIFO error, W1C of err
        in_cnt = CNT_W'(3);
        apb(1, 3'd0, 32'hDEADBEEF);
        in_cnt = CNT_W'(24);
        apb(1, 3'd1, 32'h0BAD0BAD);
        apb(0, 3'd7, 0);
        apb(1, 3'd7, 32'(1) << (KI + 2));
        apb(0, 3'd7, 0);

        // Data reads with and without FIFO content
        out_cnt = CNT_W'(2); out_data = 32'h12345678;
        apb(0, 3'd4, 0);
        out_cnt = '0;
        apb(0, 3'd4, 0);

        // Full key sequence with an encrypt attempt in the middle
        in_cnt = CNT_W'(1);
        for (int i = 0; i < KEY_WORDS; i++) begin
            apb(1, 3'd2, $urandom);
            if (i == 2) apb(1, 3'd0, 32'h1111);
            apb(0, 3'd7, 0);
        end

        // Timeout boundary: access one cycle before, exactly at, and after expiry
        apb(1, 3'd2, $urandom);
        apb(1, 3'd2, $urandom);
        repeat (252) @(posedge clk);
        apb(0, 3'd7, 0);
        repeat (252) @(posedge clk);
        apb(1, 3'd2, $urandom);
        repeat (253) @(posedge clk);
        apb(0, 3'd7, 0);
        apb(1, 3'd2, $urandom);
        apb(1, 3'd7, 32'(1) << (KI + 1));
        apb(1, 3'd3, $urandom);
        apb(0, 3'd7, 0);

        // Setup with PSEL dropped before the access phase
        @(posedge clk); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 3'd0; PWDATA = 32'hCAFE;
        @(negedge clk);
        chk("drop_setup_ready", 32'(PREADY | cmd_valid), 0);
        @(posedge clk); #1;
        PSEL = 0; PENABLE = 1;
        @(negedge clk);
        chk("drop_access_ready", 32'(PREADY | cmd_valid), 0);
        @(posedge clk); #1;
        PENABLE = 0;
        apb(1, 3'd0, 32'h5A5A5A5A);

        // Reset while the data read is in its wait state
        out_cnt = CNT_W'(3); out_data = $urandom;
        @(posedge clk); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 3'd4;
        @(posedge clk); #1;
        PENABLE = 1;
        @(negedge clk);
        chk("midrst_pop", 32'(out_pop), 1);
        chk("midrst_first_ready", 32'(PREADY), 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("midrst_ready", 32'(PREADY), 0);
        chk("midrst_prdata", PRDATA, 0);
        @(posedge clk); #1;
        rst = 0; PSEL = 0; PENABLE = 0;
        model_reset();
        apb(0, 3'd7, 0);
        apb(0, 3'd4, 0);

        // Random traffic
        for (int t = 0; t < 220; t++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) addr = 3'd2;
            in_cnt  = ($urandom_range(0, 3) == 0) ? CNT_W'(IN_DEPTH) : CNT_W'($urandom_range(0, IN_DEPTH - 1));
            out_cnt = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, OUT_DEPTH));
            out_data = $urandom;
            if ($urandom_range(0, 29) == 0) repeat ($urandom_range(248, 256)) @(posedge clk);
            else repeat ($urandom_range(0, 2)) @(posedge clk);
            apb(wr, addr, $urandom);
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_apb_ctrl.md
Name: des_apb_ctrl

Overview:
Parametrised APB3 slave controller for the 3DES accelerator. Replaces the fixed single-cycle command decoder with a full APB handshake (PENABLE/PREADY, one wait state on data reads) and a generalised key-load sequencer over KEY_WORDS words with an abort timeout. Adds a sticky status/error register. Sits between the APB bus and the datapath FIFOs and key registers, issuing one-cycle command pulses.

Parameters:
DATA_W, 32, APB data width.
IN_DEPTH, 24, input FIFO capacity in words; input is full when in_cnt == IN_DEPTH.
OUT_DEPTH, 24, output FIFO capacity in words.
KEY_WORDS, 6, number of key writes per key-load sequence (3 keys x 64 bit).
KEY_TIMEOUT, 255, idle cycles allowed between key words before the sequence aborts.
CNT_W, $clog2(IN_DEPTH+1), derived; width of the FIFO count inputs.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PADDR  in  3  word address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data; valid only in the completing read cycle, else 0
PREADY  out  1  transfer complete
PSLVERR  out  1  error; valid only when PREADY=1
in_cnt  in  CNT_W  input FIFO occupancy
out_cnt  in  CNT_W  output FIFO occupancy
out_data  in  DATA_W  output FIFO head; valid 1 cycle after out_pop
cmd  out  3  command code (package enum), CMD_NONE when idle
cmd_valid  out  1  one-cycle command strobe
key_idx  out  $clog2(KEY_WORDS)  key word index qualified by CMD_KEY
wr_data  out  DATA_W  PWDATA forwarded with cmd_valid
out_pop  out  1  one-cycle pop of the output FIFO

Behaviour:
- States: IDLE, ACCESS, RD_WAIT. IDLE -> ACCESS on PSEL & !PENABLE. In ACCESS, if PSEL drops, return to IDLE with no side effect.
- Zero-wait transfers: all writes and reads of addresses 5, 6 and 7 complete in the first cycle with PSEL & PENABLE. That cycle has PREADY=1; for writes it also carries cmd_valid and cmd.
- Address 4 read with out_cnt != 0: first access cycle has PREADY=0 and out_pop=1. Move to RD_WAIT. Next cycle has PREADY=1 and PRDATA=out_data. Return to IDLE.
- Address map: 0 CMD_ENC write, 1 CMD_DEC write, 2 CMD_KEY write, 3 CMD_RESET write, 4 data read, 5 in_cnt read, 6 out_cnt read, 7 status (read and write).
- Errors: PREADY=1 and PSLVERR=1, no cmd_valid, no out_pop, sticky err flag set. Causes:
  - write to 0 or 1 with in_cnt == IN_DEPTH;
  - read of 4 with out_cnt == 0;
  - read of 0 to 3;
  - write to 4 to 6;
  - write to 0 or 1 while a key sequence is active.
- Key sequence:
  - The first address 2 write sets key_active and issues key_idx=0. Each further write increments key_idx.
  - The write with key_idx == KEY_WORDS-1 clears key_active.
  - Timeout counter resets on every key write. Reaching KEY_TIMEOUT idle cycles clears key_active and key_idx and sets sticky key_abort.
  - Address 3 write also clears key_active and key_idx.
- Status read: {zero-pad, err, key_abort, key_active, key_idx}, key_idx in the LSBs. Status write is write-1-to-clear of err (bit KI+2) and key_abort (bit KI+1), where KI = key_idx width.
- Reset: state IDLE, key_idx 0, key_active 0, timeout counter 0, sticky flags 0. All outputs 0; cmd = CMD_NONE.
- Mid-transfer reset: the transfer is dropped with no PREADY. A pending RD_WAIT is discarded; the bus master retries.
- Simultaneous key timeout and key write in the same cycle: the write wins and the counter restarts.

Decomposition:
- Package des_apb_pkg: cmd enum (CMD_NONE=0, CMD_ENC=1, CMD_DEC=2, CMD_KEY=3, CMD_RESET=5, CMD_READ=6), address localparams, status bit positions.
- Sub-module des_key_seq: key index counter, key_active flag and timeout counter. Inputs: key_wr, abort. Outputs: key_idx, key_active, timeout_abort.

Test Plan:
- Write 0xDEADBEEF to addr 0, in_cnt=3 -> PREADY=1, PSLVERR=0, one cmd_valid cycle with cmd=1 and wr_data=0xDEADBEEF.
- Write addr 1 with in_cnt=24 -> PSLVERR=1, no cmd_valid; status read returns err=1; write 1 to the err bit at addr 7 -> err reads 0.
- Read addr 4 with out_cnt=2, out_data=0x12345678 -> one PREADY=0 cycle with out_pop=1, then PREADY=1 and PRDATA=0x12345678. Read addr 4 with out_cnt=0 -> PSLVERR=1, PRDATA=0.
- Six addr 2 writes -> key_idx 0..5 each with cmd=3, key_active clears after the 6th. An addr 0 write after the 3rd key write -> PSLVERR=1.
- Two key writes, then 255 idle cycles -> key_active=0, key_abort=1; the next addr 2 write restarts at key_idx 0.
- PSEL dropped between setup and access, and rst asserted in RD_WAIT -> no PREADY, no cmd_valid, state returns to IDLE.
